mem_port_arbiter: RTL and testbench

//  Shares the single core-memory port between three requesters: data break (DMA), front panel

---
 rtl/mem_port_arbiter_if.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, panel and memory signals around the core-memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              halt;
    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              brk_req;
    logic              brk_wr;
    logic [ADDR_W-1:0] brk_addr;
    logic [DATA_W-1:0] brk_wdata;
    logic              brk_ack;
    logic              pnl_load;
    logic [ADDR_W-1:0] pnl_addr;
    logic              pnl_exam;
    logic              pnl_dep;
    logic [DATA_W-1:0] pnl_wdata;
    logic              pnl_ack;
    logic [ADDR_W-1:0] pnl_ma;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  halt,
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_ack,
        input  brk_req, brk_wr, brk_addr, brk_wdata,
        output brk_ack,
        input  pnl_load, pnl_addr, pnl_exam, pnl_dep, pnl_wdata,
        output pnl_ack, pnl_ma,
        output rdata, mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output halt,
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_ack,
        output brk_req, brk_wr, brk_addr, brk_wdata,
        input  brk_ack,
        output pnl_load, pnl_addr, pnl_exam, pnl_dep, pnl_wdata,
        input  pnl_ack, pnl_ma,
        input  rdata, mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Core-memory port arbiter: data break > panel (halted) > CPU, with a break-burst cap for the CPU.
// Build option PANEL_AUTOINC_EN: panel MA low 12 bits step after every panel access.
module mem_port_arbiter #(
    parameter int ADDR_W        = 15,
    parameter int DATA_W        = 12,
    parameter int MAX_BRK_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int                 BURST_W   = $clog2(MAX_BRK_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BRK_BURST);

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, ACK} state_t;
    typedef enum logic [1:0] {OWN_CPU, OWN_BRK, OWN_PNL} owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0]  pnl_ma_q, pnl_ma_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               mem_we_q, mem_we_d;
    logic               cpu_ack_q, cpu_ack_d;
    logic               brk_ack_q, brk_ack_d;
    logic               pnl_ack_q, pnl_ack_d;
    logic               exam_pend_q, exam_pend_d;
    logic               dep_pend_q, dep_pend_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic pnl_active;
    logic pnl_ready;
    logic grant_cpu, grant_brk, grant_pnl;
    logic ack_set;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        rdata_d     = rdata_q;
        pnl_ma_d    = pnl_ma_q;
        exam_pend_d = exam_pend_q;
        dep_pend_d  = dep_pend_q;
        burst_d     = burst_q;
        cpu_ack_d   = 1'b0;
        brk_ack_d   = 1'b0;
        pnl_ack_d   = 1'b0;
        grant_cpu   = 1'b0;
        grant_brk   = 1'b0;
        grant_pnl   = 1'b0;
        ack_set     = 1'b0;

        // A panel op is pending or in flight: further panel pulses and loads are dropped.
        pnl_active = exam_pend_q || dep_pend_q || (state_q != IDLE && owner_q == OWN_PNL);
        pnl_ready  = (exam_pend_q || dep_pend_q) && bus.halt;

        if (!pnl_active) begin
            if (bus.pnl_load) pnl_ma_d = bus.pnl_addr;
            if (bus.pnl_dep)       dep_pend_d  = 1'b1;
            else if (bus.pnl_exam) exam_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_req && burst_q == BURST_MAX) grant_cpu = 1'b1;
                else if (bus.brk_req)                    grant_brk = 1'b1;
                else if (pnl_ready)                      grant_pnl = 1'b1;
                else if (bus.cpu_req)                    grant_cpu = 1'b1;

                if (grant_cpu) begin
                    owner_d     = OWN_CPU;
                    mem_addr_d  = bus.cpu_addr;
                    mem_wdata_d = bus.cpu_wdata;
                    mem_we_d    = bus.cpu_wr;
                    burst_d     = '0;
                end
                if (grant_brk) begin
                    owner_d     = OWN_BRK;
                    mem_addr_d  = bus.brk_addr;
                    mem_wdata_d = bus.brk_wdata;
                    mem_we_d    = bus.brk_wr;
                    burst_d     = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);
                end
                if (grant_pnl) begin
                    owner_d     = OWN_PNL;
                    mem_addr_d  = pnl_ma_q;
                    mem_wdata_d = bus.pnl_wdata;
                    mem_we_d    = dep_pend_q;
                    burst_d     = '0;
                    exam_pend_d = 1'b0;
                    dep_pend_d  = 1'b0;
                end
                if (grant_cpu || grant_brk || grant_pnl) state_d = ACCESS;
            end
            ACCESS: begin
                // mem_we_q doubles as the registered read/write flag of the granted access.
                if (mem_we_q) begin
                    ack_set = 1'b1;
                    state_d = ACK;
                end else begin
                    state_d = RWAIT;
                end
            end
            RWAIT: begin
                rdata_d = bus.mem_rdata;
                ack_set = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
`ifdef PANEL_AUTOINC_EN
                if (owner_q == OWN_PNL)
                    pnl_ma_d = {pnl_ma_q[ADDR_W-1:12], pnl_ma_q[11:0] + 12'd1};
`endif
            end
            default: state_d = IDLE;
        endcase

        if (ack_set) begin
            cpu_ack_d = (owner_q == OWN_CPU);
            brk_ack_d = (owner_q == OWN_BRK);
            pnl_ack_d = (owner_q == OWN_PNL);
        end

        if (!bus.halt) begin
            exam_pend_d = 1'b0;
            dep_pend_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rdata_q     <= '0;
            pnl_ma_q    <= '0;
            exam_pend_q <= 1'b0;
            dep_pend_q  <= 1'b0;
            burst_q     <= '0;
            cpu_ack_q   <= 1'b0;
            brk_ack_q   <= 1'b0;
            pnl_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
            pnl_ma_q    <= pnl_ma_d;
            exam_pend_q <= exam_pend_d;
            dep_pend_q  <= dep_pend_d;
            burst_q     <= burst_d;
            cpu_ack_q   <= cpu_ack_d;
            brk_ack_q   <= brk_ack_d;
            pnl_ack_q   <= pnl_ack_d;
        end
    end

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.brk_ack   = brk_ack_q;
    assign bus.pnl_ack   = pnl_ack_q;
    assign bus.pnl_ma    = pnl_ma_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, then random CPU/break traffic vs a shadow memory.
// Build with PANEL_AUTOINC_EN defined to check the auto-incrementing panel MA.
module tb_mem_port_arbiter;
    localparam int ADDR_W  = 15;
    localparam int DATA_W  = 12;
    localparam int MAX_BRK = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BRK_BURST(MAX_BRK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory with one-cycle read latency plus a backdoor for preloading.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [DATA_W-1:0] bd_data;
    always @(posedge clk) begin
        if (bus.mem_we)  mem[bus.mem_addr] <= bus.mem_wdata;
        else if (bd_we)  mem[bd_addr]      <= bd_data;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0o expected=%0o", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.cpu_ack) $display("txn cyc=%0d cpu addr=%05o we_last=%0d rdata=%04o", cyc, bus.mem_addr, bus.mem_we, bus.rdata);
        if (bus.brk_ack) $display("txn cyc=%0d brk addr=%05o rdata=%04o", cyc, bus.mem_addr, bus.rdata);
        if (bus.pnl_ack) $display("txn cyc=%0d pnl addr=%05o rdata=%04o ma=%05o", cyc, bus.mem_addr, bus.rdata, bus.pnl_ma);
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick();
        bd_we = 1'b0;
    endtask

    // Expected panel MA after one completed panel access.
    function automatic logic [ADDR_W-1:0] ma_after(input logic [ADDR_W-1:0] ma);
`ifdef PANEL_AUTOINC_EN
        return (ma & 15'o70000) | ((ma + 15'd1) & 15'o07777);
`else
        return ma;
`endif
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [DATA_W-1:0] shadow [0:15];
    logic [5:0]        order;
    int                n, cnt, we_cnt, ack_cnt, seen;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] we_data;
    logic              c_act, c_wr, b_act, b_wr;
    logic [3:0]        c_addr, b_addr;
    logic [DATA_W-1:0] c_data, b_data;
    int                c_wait, b_wait, c_raise, brun, ncpu, nbrk;

    initial begin
        reset = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        bus.halt = 1'b0;
        bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.brk_req = 1'b0; bus.brk_wr = 1'b0; bus.brk_addr = '0; bus.brk_wdata = '0;
        bus.pnl_load = 1'b0; bus.pnl_addr = '0; bus.pnl_exam = 1'b0; bus.pnl_dep = 1'b0; bus.pnl_wdata = '0;
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_ma", bus.pnl_ma, 0);
        chk("rst_acks", {bus.cpu_ack, bus.brk_ack, bus.pnl_ack}, 0);
        reset = 1'b0;
        preload(15'o00200, 12'o4402);

        // 1: CPU read latency, then CPU write latency.
        bus.cpu_addr = 15'o00200; bus.cpu_wr = 1'b0; bus.cpu_req = 1'b1;
        tick();
        chk("t1_addr_n1", bus.mem_addr, 15'o00200);
        chk("t1_we_n1", bus.mem_we, 0);
        chk("t1_busy_n1", bus.busy, 1);
        tick();
        chk("t1_ack_n2", bus.cpu_ack, 0);
        tick();
        chk("t1_ack_n3", bus.cpu_ack, 1);
        chk("t1_rdata_n3", bus.rdata, 12'o4402);
        bus.cpu_req = 1'b0;
        tick();
        chk("t1_ack_pulse", bus.cpu_ack, 0);
        chk("t1_rdata_hold", bus.rdata, 12'o4402);
        bus.cpu_addr = 15'o00201; bus.cpu_wdata = 12'o1357; bus.cpu_wr = 1'b1; bus.cpu_req = 1'b1;
        tick();
        chk("t1w_we_n1", bus.mem_we, 1);
        chk("t1w_wdata_n1", bus.mem_wdata, 12'o1357);
        tick();
        chk("t1w_ack_n2", bus.cpu_ack, 1);
        chk("t1w_we_n2", bus.mem_we, 0);
        bus.cpu_req = 1'b0;
        tick();

        // 2: break burst cap lets the CPU in after MAX_BRK grants.
        bus.brk_addr = 15'o00300; bus.brk_wdata = 12'o0055; bus.brk_wr = 1'b1; bus.brk_req = 1'b1;
        bus.cpu_addr = 15'o00201; bus.cpu_wr = 1'b0; bus.cpu_req = 1'b1;
        order = '0; n = 0;
        for (int i = 0; i < 60 && n < 6; i++) begin
            tick();
            if (bus.cpu_ack) begin
                order[n] = 1'b1; n++; bus.cpu_req = 1'b0;
                chk("t2_cpu_rdata", bus.rdata, 12'o1357);
            end
            if (bus.brk_ack) begin
                n++;
                if (n >= 6) bus.brk_req = 1'b0;
            end
        end
        bus.brk_req = 1'b0; bus.cpu_req = 1'b0;
        chk("t2_ack_count", n, 6);
        chk("t2_order", order, 6'b010000);
        tick();
        chk("t2_idle", bus.busy, 0);

        // 3: panel load then deposit.
        bus.halt = 1'b1;
        bus.pnl_addr = 15'o07777; bus.pnl_load = 1'b1;
        tick();
        bus.pnl_load = 1'b0;
        chk("t3_ma_load", bus.pnl_ma, 15'o07777);
        bus.pnl_wdata = 12'o7000; bus.pnl_dep = 1'b1;
        tick();
        bus.pnl_dep = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (bus.mem_we) begin
                seen = 1;
                chk("t3_we_addr", bus.mem_addr, 15'o07777);
                chk("t3_we_data", bus.mem_wdata, 12'o7000);
            end
        end
        chk("t3_we_seen", seen, 1);
        tick();
        chk("t3_ack", bus.pnl_ack, 1);
        tick();
        chk("t3_ma_after", bus.pnl_ma, ma_after(15'o07777));

        // 4: exam while running is discarded, even once halted later.
        bus.halt = 1'b0;
        tick();
        bus.pnl_exam = 1'b1;
        tick();
        bus.pnl_exam = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) bus.halt = 1'b1;
            tick();
            if (bus.busy || bus.mem_we || bus.pnl_ack) cnt++;
        end
        chk("t4_no_access", cnt, 0);

        // 5: simultaneous exam+dep gives one write, then exam reads it back.
        bus.pnl_addr = 15'o00050; bus.pnl_load = 1'b1;
        tick();
        bus.pnl_load = 1'b0;
        bus.pnl_wdata = 12'o1234; bus.pnl_exam = 1'b1; bus.pnl_dep = 1'b1;
        tick();
        bus.pnl_exam = 1'b0; bus.pnl_dep = 1'b0;
        we_cnt = 0; ack_cnt = 0; we_addr = '0; we_data = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.mem_we) begin we_cnt++; we_addr = bus.mem_addr; we_data = bus.mem_wdata; end
            if (bus.pnl_ack) ack_cnt++;
        end
        chk("t5_we_count", we_cnt, 1);
        chk("t5_ack_count", ack_cnt, 1);
        chk("t5_we_addr", we_addr, 15'o00050);
        chk("t5_we_data", we_data, 12'o1234);
        bus.pnl_addr = 15'o00050; bus.pnl_load = 1'b1;
        tick();
        bus.pnl_load = 1'b0; bus.pnl_exam = 1'b1;
        tick();
        bus.pnl_exam = 1'b0;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            tick();
            if (bus.pnl_ack) begin
                seen = 1;
                chk("t5_exam_rdata", bus.rdata, 12'o1234);
                chk("t5_exam_we", bus.mem_we, 0);
            end
        end
        chk("t5_exam_seen", seen, 1);
        bus.halt = 1'b0;
        tick();

        // 6: reset during RWAIT abandons the read.
        bus.cpu_addr = 15'o00050; bus.cpu_wr = 1'b0; bus.cpu_req = 1'b1;
        tick(); tick();
        reset = 1'b1; bus.cpu_req = 1'b0;
        tick();
        chk("t6_ack", bus.cpu_ack, 0);
        chk("t6_busy", bus.busy, 0);
        chk("t6_we", bus.mem_we, 0);
        chk("t6_addr", bus.mem_addr, 0);
        chk("t6_rdata", bus.rdata, 0);
        chk("t6_ma", bus.pnl_ma, 0);
        reset = 1'b0;
        tick();

        // Random CPU/break traffic against a shadow memory.
        for (int a = 0; a < 16; a++) begin
            shadow[a] = DATA_W'($urandom);
            preload(15'(a), shadow[a]);
        end
        c_act = 1'b0; b_act = 1'b0; c_wait = 0; b_wait = 0; c_raise = 0; brun = 0; ncpu = 0; nbrk = 0;
        c_wr = 1'b0; b_wr = 1'b0; c_addr = '0; b_addr = '0; c_data = '0; b_data = '0;
        for (int i = 0; i < 2500; i++) begin
            tick();
            if (c_act) begin
                if (bus.cpu_ack) begin
                    if (!c_wr) chk("rnd_cpu_rdata", bus.rdata, shadow[c_addr]);
                    else shadow[c_addr] = c_data;
                    chk("rnd_burst_cap", (brun <= MAX_BRK), 1);
                    c_act = 1'b0; bus.cpu_req = 1'b0; ncpu++;
                end else begin
                    c_wait++;
                    if (c_wait > 40) begin
                        chk("rnd_cpu_wait", c_wait, 40);
                        c_act = 1'b0; bus.cpu_req = 1'b0;
                    end
                end
            end else begin
                chk("rnd_cpu_stray", bus.cpu_ack, 0);
                if (i < 2450 && $urandom_range(0, 2) == 0) begin
                    c_wr = 1'($urandom_range(0, 1)); c_addr = 4'($urandom_range(0, 15)); c_data = DATA_W'($urandom);
                    bus.cpu_wr = c_wr; bus.cpu_addr = 15'(c_addr); bus.cpu_wdata = c_data; bus.cpu_req = 1'b1;
                    c_act = 1'b1; c_wait = 0; c_raise = cyc; brun = 0;
                end
            end
            if (b_act) begin
                if (bus.brk_ack) begin
                    if (!b_wr) chk("rnd_brk_rdata", bus.rdata, shadow[b_addr]);
                    else shadow[b_addr] = b_data;
                    if (c_act && cyc >= c_raise + 3) brun++;
                    b_act = 1'b0; bus.brk_req = 1'b0; nbrk++;
                end else begin
                    b_wait++;
                    if (b_wait > 40) begin
                        chk("rnd_brk_wait", b_wait, 40);
                        b_act = 1'b0; bus.brk_req = 1'b0;
                    end
                end
            end else begin
                chk("rnd_brk_stray", bus.brk_ack, 0);
                if (i < 2450 && $urandom_range(0, 3) != 0) begin
                    b_wr = 1'($urandom_range(0, 1)); b_addr = 4'($urandom_range(0, 15)); b_data = DATA_W'($urandom);
                    bus.brk_wr = b_wr; bus.brk_addr = 15'(b_addr); bus.brk_wdata = b_data; bus.brk_req = 1'b1;
                    b_act = 1'b1; b_wait = 0;
                end
            end
        end
        chk("rnd_progress", (ncpu > 50 && nbrk > 50), 1);
        chk("rnd_drained", {c_act, b_act, bus.busy}, 0);
        for (int a = 0; a < 16; a++) chk("rnd_mem_final", mem[a], shadow[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
